btb_update_unit: RTL and testbench

- Write-side companion of the BTB set-read logic.
- Accepts one resolved-branch update at a time, reads the addressed 128-bit set from BTB storage, and merges the outcome into it:
  - on a hit, trains the 2-bit predictor and updates the target;
  - on a taken miss, allocates a way.
- Writes the merged set back.
- Also performs a full invalidate sweep on request.
- Sits between the execute-stage branch resolution and the BTB set array.

---
 rtl/btb_pkg.sv | 25 ++
 rtl/btb_ctr_update.sv | 10 +
 rtl/btb_update_unit.sv | 146 ++++++++++++++
 tb/tb_btb_update_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: set/way field positions, widths and controller states for the BTB update unit.
package btb_pkg;
   localparam int SET_W   = 128;
   localparam int WAY_W   = 64;
   localparam int TAG_W   = 27;
   localparam int TGT_W   = 32;
   localparam int WAY1_LO = 64;
   localparam int V_BIT   = 63;
   localparam int TAG_HI  = 62;
   localparam int TAG_LO  = 36;
   localparam int TGT_HI  = 35;
   localparam int TGT_LO  = 4;
   localparam int FSM_HI  = 3;
   localparam int FSM_LO  = 2;
   localparam int LRU_BIT = 0;
   localparam logic [1:0] FSM_INIT = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_MERGE, S_WRITE, S_FLUSH} state_t;

   // Low two way bits are reserved/LRU and belong to the set, so they are carried through.
   function automatic logic [WAY_W-1:0] way_put(input logic [1:0] keep, input logic [TAG_W-1:0] tag,
                                                input logic [TGT_W-1:0] tgt, input logic [1:0] fsm);
      return {1'b1, tag, tgt, fsm, keep};
   endfunction
endpackage

// File: rtl/btb_ctr_update.sv
// btb_ctr_update: 2-bit saturating direction counter update.
module btb_ctr_update (
   input  logic [1:0] ctr_in,
   input  logic       taken,
   output logic [1:0] ctr_out
);
   always_comb
      ctr_out = taken ? ((ctr_in == 2'b11) ? ctr_in : ctr_in + 2'd1)
                      : ((ctr_in == 2'b00) ? ctr_in : ctr_in - 2'd1);
endmodule

// File: rtl/btb_update_unit.sv
// btb_update_unit: read-merge-write of resolved branches into the BTB set array, plus invalidate sweep.
module btb_update_unit
   import btb_pkg::*;
#(
   parameter int NUM_SETS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd_valid,
   output logic             upd_ready,
   input  logic [31:0]      upd_pc,
   input  logic [31:0]      upd_target,
   input  logic             upd_taken,
   input  logic             flush,
   output logic             rd_en,
   output logic [2:0]       rd_index,
   input  logic [SET_W-1:0] rd_data,
   output logic             wr_en,
   output logic [2:0]       wr_index,
   output logic [SET_W-1:0] wr_data
);
   state_t state_q, state_d;
   logic flush_pend_q, flush_pend_d;
   logic [2:0] cnt_q, cnt_d;
   logic [31:2] pc_q, pc_d;
   logic [TGT_W-1:0] tgt_q, tgt_d;
   logic taken_q, taken_d;
   logic rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic [2:0] rd_index_q, rd_index_d, wr_index_q, wr_index_d;
   logic [SET_W-1:0] wr_data_q, wr_data_d;
   logic [WAY_W-1:0] w1, w2, new_way;
   logic [TAG_W-1:0] tag;
   logic hit1, hit2, hit, sel1, need_wr;
   logic [TGT_W-1:0] old_tgt;
   logic [1:0] old_fsm, old_lo, ctr_out;
   logic [SET_W-1:0] merged;
   logic unused_pc;

   assign unused_pc = ^upd_pc[1:0];

   assign w1   = rd_data[SET_W-1:WAY1_LO];
   assign w2   = rd_data[WAY_W-1:0];
   assign tag  = pc_q[31:5];
   assign hit1 = w1[V_BIT] && (w1[TAG_HI:TAG_LO] == tag);
   assign hit2 = w2[V_BIT] && (w2[TAG_HI:TAG_LO] == tag);
   assign hit  = hit1 | hit2;
   // Way1 wins a double hit; on a miss prefer invalid way1, then invalid way2, then the LRU victim.
   assign sel1 = hit ? hit1 : (!w1[V_BIT] | (w2[V_BIT] & !rd_data[LRU_BIT]));
   assign old_tgt = sel1 ? w1[TGT_HI:TGT_LO] : w2[TGT_HI:TGT_LO];
   assign old_fsm = sel1 ? w1[FSM_HI:FSM_LO] : w2[FSM_HI:FSM_LO];
   assign old_lo  = sel1 ? w1[1:0] : w2[1:0];
   assign need_wr = hit | taken_q;

   btb_ctr_update u_ctr (.ctr_in(old_fsm), .taken(taken_q), .ctr_out(ctr_out));

   assign new_way = way_put(old_lo, tag, (hit && !taken_q) ? old_tgt : tgt_q, hit ? ctr_out : FSM_INIT);
   assign merged  = sel1 ? {new_way, rd_data[WAY_W-1:1], 1'b1}
                         : {rd_data[SET_W-1:WAY1_LO], new_way[WAY_W-1:1], 1'b0};

   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q | flush;
      cnt_d        = cnt_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      taken_d      = taken_q;
      rd_en_d      = 1'b0;
      rd_index_d   = rd_index_q;
      wr_en_d      = 1'b0;
      wr_index_d   = wr_index_q;
      wr_data_d    = wr_data_q;
      case (state_q)
         S_IDLE:
            if (flush_pend_q) begin
               state_d      = S_FLUSH;
               flush_pend_d = flush;
               cnt_d        = 3'd0;
               wr_en_d      = 1'b1;
               wr_index_d   = 3'd0;
               wr_data_d    = '0;
            end else if (upd_valid) begin
               state_d    = S_READ;
               pc_d       = upd_pc[31:2];
               tgt_d      = upd_target;
               taken_d    = upd_taken;
               rd_en_d    = 1'b1;
               rd_index_d = upd_pc[4:2];
            end
         S_READ: state_d = S_MERGE;
         S_MERGE:
            if (need_wr) begin
               state_d    = S_WRITE;
               wr_en_d    = 1'b1;
               wr_index_d = pc_q[4:2];
               wr_data_d  = merged;
            end else begin
               state_d = S_IDLE;
            end
         S_WRITE: state_d = S_IDLE;
         S_FLUSH:
            if (cnt_q == 3'(NUM_SETS - 1)) begin
               state_d = S_IDLE;
            end else begin
               cnt_d      = cnt_q + 3'd1;
               wr_en_d    = 1'b1;
               wr_index_d = cnt_q + 3'd1;
            end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         flush_pend_q <= 1'b0;
         cnt_q        <= 3'd0;
         pc_q         <= '0;
         tgt_q        <= '0;
         taken_q      <= 1'b0;
         rd_en_q      <= 1'b0;
         rd_index_q   <= 3'd0;
         wr_en_q      <= 1'b0;
         wr_index_q   <= 3'd0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         cnt_q        <= cnt_d;
         pc_q         <= pc_d;
         tgt_q        <= tgt_d;
         taken_q      <= taken_d;
         rd_en_q      <= rd_en_d;
         rd_index_q   <= rd_index_d;
         wr_en_q      <= wr_en_d;
         wr_index_q   <= wr_index_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign upd_ready = (state_q == S_IDLE) && !flush_pend_q;
   assign rd_en     = rd_en_q;
   assign rd_index  = rd_index_q;
   assign wr_en     = wr_en_q;
   assign wr_index  = wr_index_q;
   assign wr_data   = wr_data_q;
endmodule

// File: tb/tb_btb_update_unit.sv
// tb_btb_update_unit: table-driven merge vectors plus flush/reset sequences, writes checked via a scoreboard.
module tb_btb_update_unit;
   logic clk = 1'b0, rst = 1'b1;
   logic upd_valid = 1'b0, upd_ready, upd_taken = 1'b0, flush = 1'b0;
   logic [31:0] upd_pc = '0, upd_target = '0;
   logic rd_en, wr_en;
   logic [2:0] rd_index, wr_index;
   logic [127:0] rd_data, wr_data;

   btb_update_unit #(.NUM_SETS(8)) dut (
      .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
      .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush), .rd_en(rd_en),
      .rd_index(rd_index), .rd_data(rd_data), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   logic [127:0] mem [8];
   logic pl_en = 1'b0;
   logic [2:0] pl_idx = '0;
   logic [127:0] pl_data = '0;

   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_index];
      if (wr_en) mem[wr_index] <= wr_data;
      else if (pl_en) mem[pl_idx] <= pl_data;
   end

   typedef struct {
      logic [2:0] idx;
      logic [127:0] data;
   } wr_t;
   wr_t sbq[$];
   wr_t mon_e;
   int checks = 0, errors = 0;

   always @(negedge clk) begin
      if (wr_en) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write idx=%0d data=%h", wr_index, wr_data);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.idx !== wr_index || mon_e.data !== wr_data) begin
               errors++;
               $display("FAIL write got idx=%0d data=%h want idx=%0d data=%h", wr_index, wr_data, mon_e.idx, mon_e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mk_set(input logic v1, input logic [26:0] t1, input logic [31:0] g1,
                                           input logic [1:0] f1, input logic v2, input logic [26:0] t2,
                                           input logic [31:0] g2, input logic [1:0] f2,
                                           input logic [2:0] rsv, input logic lru);
      return {v1, t1, g1, f1, rsv[2:1], v2, t2, g2, f2, rsv[0], lru};
   endfunction

   task automatic preload(input logic [2:0] idx, input logic [127:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!upd_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!upd_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got=0 want=1");
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
      @(posedge clk);
      #1 upd_valid = 1'b0;
   endtask

   task automatic apply(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic wr, input logic [127:0] exp);
      wait_ready();
      if (wr) sbq.push_back(wr_t'{pc[4:2], exp});
      drive(pc, tgt, tk);
      @(negedge clk);
      chk("t1_rd_en", 128'(rd_en), 128'(1));
      chk("t1_rd_index", 128'(rd_index), 128'(pc[4:2]));
      @(negedge clk);
      chk("t2_wr_en", 128'(wr_en), 128'(0));
      @(negedge clk);
      chk("t3_wr_en", 128'(wr_en), 128'(wr));
      chk("t3_ready", 128'(upd_ready), 128'(!wr));
      if (wr) begin
         @(negedge clk);
         chk("t4_ready", 128'(upd_ready), 128'(1));
      end
   endtask

   typedef struct {
      logic [127:0] pre;
      logic [31:0] pc, tgt;
      logic taken, wr, way1;
      logic [1:0] efsm;
      logic [31:0] etgt;
      logic elru;
   } vec_t;
   vec_t v [11];

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] exp, s;
      logic [31:0] pc;
      v[0]  = '{128'h0, 32'h1008, 32'h2000, 1'b1, 1'b1, 1'b1, 2'b10, 32'h2000, 1'b1};
      s = mk_set(1'b1, 27'h80, 32'h2000, 2'b11, 1'b0, 27'h0, 32'h0, 2'b00, 3'b000, 1'b1);
      v[1]  = '{s, 32'h1008, 32'h3000, 1'b1, 1'b1, 1'b1, 2'b11, 32'h3000, 1'b1};
      v[2]  = '{s, 32'h1008, 32'h4444, 1'b0, 1'b1, 1'b1, 2'b10, 32'h2000, 1'b1};
      s = mk_set(1'b1, 27'h11, 32'h1111, 2'b01, 1'b1, 27'h22, 32'h2222, 2'b00, 3'b111, 1'b0);
      v[3]  = '{s, 32'h674, 32'hABCD0000, 1'b1, 1'b1, 1'b1, 2'b10, 32'hABCD0000, 1'b1};
      s[0] = 1'b1;
      v[4]  = '{s, 32'h674, 32'hABCD0000, 1'b1, 1'b1, 1'b0, 2'b10, 32'hABCD0000, 1'b0};
      s = mk_set(1'b0, 27'h33, 32'h1111, 2'b11, 1'b1, 27'h33, 32'h2222, 2'b01, 3'b101, 1'b0);
      v[5]  = '{s, 32'h674, 32'h5555, 1'b1, 1'b1, 1'b0, 2'b10, 32'h5555, 1'b0};
      s = mk_set(1'b1, 27'h33, 32'h1111, 2'b00, 1'b1, 27'h33, 32'h2222, 2'b01, 3'b010, 1'b0);
      v[6]  = '{s, 32'h674, 32'h9999, 1'b0, 1'b1, 1'b1, 2'b00, 32'h1111, 1'b1};
      s = mk_set(1'b1, 27'h11, 32'h1111, 2'b01, 1'b1, 27'h22, 32'h2222, 2'b10, 3'b000, 1'b0);
      v[7]  = '{s, 32'h674, 32'h9999, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0};
      s = mk_set(1'b1, 27'h11, 32'h1111, 2'b01, 1'b0, 27'h33, 32'h2222, 2'b11, 3'b110, 1'b0);
      v[8]  = '{s, 32'h674, 32'h7777, 1'b1, 1'b1, 1'b0, 2'b10, 32'h7777, 1'b0};
      s = mk_set(1'b0, 27'h0, 32'h0, 2'b00, 1'b1, 27'h7FFFFFF, 32'hCAFE0000, 2'b01, 3'b000, 1'b1);
      v[9]  = '{s, 32'hFFFFFFFC, 32'h1234, 1'b0, 1'b1, 1'b0, 2'b00, 32'hCAFE0000, 1'b0};
      s = mk_set(1'b0, 27'h5, 32'h1, 2'b01, 1'b0, 27'h6, 32'h2, 2'b10, 3'b011, 1'b1);
      v[10] = '{s, 32'h20, 32'h40, 1'b1, 1'b1, 1'b1, 2'b10, 32'h40, 1'b1};

      repeat (3) @(negedge clk);
      chk("rst_rd_en", 128'(rd_en), 128'(0));
      chk("rst_wr_en", 128'(wr_en), 128'(0));
      chk("rst_ready", 128'(upd_ready), 128'(1));
      chk("rst_wr_data", wr_data, 128'(0));
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         pc = v[i].pc;
         preload(pc[4:2], v[i].pre);
         exp = v[i].pre;
         if (v[i].way1) exp[127:64] = {1'b1, pc[31:5], v[i].etgt, v[i].efsm, v[i].pre[65:64]};
         else exp[63:2] = {1'b1, pc[31:5], v[i].etgt, v[i].efsm};
         exp[0] = v[i].elru;
         apply(pc, v[i].tgt, v[i].taken, v[i].wr, exp);
      end

      // Reset while the merge is in progress: the pending write must vanish.
      preload(3'd6, 128'h0);
      wait_ready();
      drive(32'h18, 32'h8000, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_wr_en", 128'(wr_en), 128'(0));
      chk("mrst_rd_en", 128'(rd_en), 128'(0));
      chk("mrst_rd_index", 128'(rd_index), 128'(0));
      chk("mrst_wr_index", 128'(wr_index), 128'(0));
      chk("mrst_wr_data", wr_data, 128'(0));
      chk("mrst_ready", 128'(upd_ready), 128'(1));
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("mrst_no_write", 128'(wr_en), 128'(0));
      end

      // Flush during READ: the update completes first, then an 8-set zero sweep.
      preload(3'd3, 128'h0);
      wait_ready();
      sbq.push_back(wr_t'{3'd3, {1'b1, 27'h80, 32'h5000, 2'b10, 2'b00, 63'b0, 1'b1}});
      drive(32'h100C, 32'h5000, 1'b1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      for (int i = 0; i < 8; i++) sbq.push_back(wr_t'{3'(i), 128'h0});
      for (int k = 2; k <= 13; k++) begin
         @(negedge clk);
         chk($sformatf("fl_ready_t%0d", k), 128'(upd_ready), 128'(k == 13));
         chk($sformatf("fl_wr_en_t%0d", k), 128'(wr_en), 128'(k == 3 || (k >= 5 && k <= 12)));
      end

      repeat (3) @(negedge clk);
      chk("sb_drained", 128'(sbq.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
